// File: rtl/imem_loader_if.sv
// Bundle of the loader's byte-stream handshake, instruction memory write
// port and boot status lines. The master side feeds bytes in; the slave
// side is the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_reset_n;
  logic              load_done;
  logic              load_error;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_reset_n, load_done, load_error
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata,
    output cpu_reset_n, load_done, load_error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader. Parses SYNC, LEN, LEN x {hi, lo}, CSUM frames
// from a byte stream, writes each assembled word into instruction memory at
// consecutive addresses and releases the CPU only after a frame whose XOR
// checksum matches. All outputs are registered alongside the state.
module imem_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN,
    S_HI,
    S_LO,
    S_WR,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [7:0]        len;
  logic [7:0]        hi;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_idx;
  logic              accept;
  logic              is_sync;

  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              cpu_reset_n_q;
  logic              done_q;
  logic              error_q;

  assign accept   = bus.rx_valid & ready_q;
  assign is_sync  = (bus.rx_data == SYNC_BYTE);
  assign last_idx = ADDR_W'(len - 8'd1);

  assign bus.rx_ready    = ready_q;
  assign bus.imem_we     = we_q;
  assign bus.imem_addr   = addr_q;
  assign bus.imem_wdata  = wdata_q;
  assign bus.cpu_reset_n = cpu_reset_n_q;
  assign bus.load_done   = done_q;
  assign bus.load_error  = error_q;

  // Frame parser FSM; each output register is updated on the transition
  // that enters or leaves the state it decodes, so it always equals a
  // Moore decode of the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_SYNC;
      len           <= '0;
      hi            <= '0;
      csum          <= '0;
      idx           <= '0;
      ready_q       <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cpu_reset_n_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      case (state)
        S_SYNC: begin
          if (accept && is_sync) begin
            state <= S_LEN;
            csum  <= '0;
            idx   <= '0;
          end
        end
        S_LEN: begin
          if (accept) begin
            if (bus.rx_data == 8'd0) begin
              state   <= S_ERR;
              error_q <= 1'b1;
            end else begin
              len   <= bus.rx_data;
              state <= S_HI;
            end
          end
        end
        S_HI: begin
          if (accept) begin
            hi    <= bus.rx_data;
            csum  <= csum ^ bus.rx_data;
            state <= S_LO;
          end
        end
        S_LO: begin
          if (accept) begin
            csum    <= csum ^ bus.rx_data;
            state   <= S_WR;
            we_q    <= 1'b1;
            addr_q  <= idx;
            wdata_q <= {hi, bus.rx_data};
            ready_q <= 1'b0;
          end
        end
        S_WR: begin
          if (idx == last_idx) begin
            state <= S_CSUM;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_HI;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (bus.rx_data == csum) begin
              state         <= S_DONE;
              cpu_reset_n_q <= 1'b1;
              done_q        <= 1'b1;
            end else begin
              state   <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (accept && is_sync) begin
            state         <= S_LEN;
            csum          <= '0;
            idx           <= '0;
            cpu_reset_n_q <= 1'b0;
            done_q        <= 1'b0;
          end
        end
        S_ERR: begin
          if (accept && is_sync) begin
            state   <= S_LEN;
            csum    <= '0;
            idx     <= '0;
            error_q <= 1'b0;
          end
        end
        default: begin
          state         <= S_SYNC;
          cpu_reset_n_q <= 1'b0;
          done_q        <= 1'b0;
          error_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frame table, hand-written reset and
// re-load sequences, and random framed streams checked against a frame
// parser model working directly on the byte list.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic clk;
  logic reset;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.SYNC_BYTE(8'hA5), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [23:0] got[$];
  logic [23:0] exp_wr[$];
  int          exp_status = 0;
  logic        prev_we = 1'b0;

  typedef struct {
    string        name;
    bit           pre_sync;
    int           n;
    logic [127:0] bytes;
    int           nw;
    logic [95:0]  wr;
    bit           done;
    bit           err;
  } vec_t;

  vec_t vecs[5];

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run wedges somewhere unexpected.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Records every memory write and checks the write-cycle handshake rules.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      got.push_back({bus.imem_addr, bus.imem_wdata});
      check_output("ready_low_in_wr", 32'(bus.rx_ready), 32'd0);
      check_output("we_single_cycle", 32'(prev_we), 32'd0);
    end
    prev_we = (bus.imem_we === 1'b1);
  end

  // Offers one byte after an optional idle gap and waits until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      bus.rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = bus.rx_ready;
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    check_output("byte_accepted", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_writes(input string tag);
    check_output({tag, "_nwrites"}, 32'(got.size()), 32'(exp_wr.size()));
    for (int k = 0; k < exp_wr.size() && k < got.size(); k++)
      check_output({tag, "_write"}, 32'(got[k]), 32'(exp_wr[k]));
  endtask

  // Reference parser: locate the sync byte, read the length, pull words
  // out by position and compare the trailing byte to their XOR.
  task automatic ref_parse(input logic [7:0] s[$]);
    int p;
    int n;
    logic [7:0] x;
    exp_wr.delete();
    p = -1;
    for (int i = 0; i < s.size() && p < 0; i++)
      if (s[i] == 8'hA5) p = i;
    if (p < 0) return;
    n = int'(s[p+1]);
    if (n == 0) begin
      exp_status = 2;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      exp_wr.push_back({8'(w), s[p+2+2*w], s[p+3+2*w]});
      x = x ^ s[p+2+2*w] ^ s[p+3+2*w];
    end
    exp_status = (s[p+2+2*n] == x) ? 1 : 2;
  endtask

  task automatic apply_stimulus(input vec_t v);
    got.delete();
    exp_wr.delete();
    for (int k = 0; k < v.nw; k++) exp_wr.push_back(v.wr[95-24*k -: 24]);
    if (v.pre_sync) begin
      send_byte(8'hA5, 0);
      check_output({v.name, "_reload_rstn"}, 32'(bus.cpu_reset_n), 32'd0);
      check_output({v.name, "_reload_done"}, 32'(bus.load_done), 32'd0);
    end
    for (int i = 0; i < v.n; i++) begin
      if (i == v.n - 1) begin
        check_output({v.name, "_pre_done"}, 32'(bus.load_done), 32'd0);
        check_output({v.name, "_pre_err"}, 32'(bus.load_error), 32'd0);
      end
      send_byte(v.bytes[127-8*i -: 8], 0);
    end
    check_output({v.name, "_done"}, 32'(bus.load_done), 32'(v.done));
    check_output({v.name, "_rstn"}, 32'(bus.cpu_reset_n), 32'(v.done));
    check_output({v.name, "_err"}, 32'(bus.load_error), 32'(v.err));
    idle(3);
    check_writes(v.name);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] b;
    logic [7:0] x;
    int len;

    vecs[0] = '{"normal", 1'b0, 11, {88'hA5_04_48_10_12_00_70_20_80_05_9F, 40'h0},
                4, {24'h00_4810, 24'h01_1200, 24'h02_7020, 24'h03_8005}, 1'b1, 1'b0};
    vecs[1] = '{"reload", 1'b1, 4, {32'h01_AB_CD_66, 96'h0},
                1, {24'h00_ABCD, 72'h0}, 1'b1, 1'b0};
    vecs[2] = '{"badcsum", 1'b0, 11, {88'hA5_04_48_10_12_00_70_20_80_05_9E, 40'h0},
                4, {24'h00_4810, 24'h01_1200, 24'h02_7020, 24'h03_8005}, 1'b0, 1'b1};
    vecs[3] = '{"zerolen", 1'b0, 2, {16'hA5_00, 112'h0},
                0, 96'h0, 1'b0, 1'b1};
    vecs[4] = '{"garbage", 1'b0, 8, {64'h00_FF_5A_A5_01_12_34_26, 64'h0},
                1, {24'h00_1234, 72'h0}, 1'b1, 1'b0};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    reset        = 1'b0;

    // Reset behaviour.
    @(posedge clk);
    #1;
    check_output("rst_ready", 32'(bus.rx_ready), 32'd0);
    check_output("rst_rstn", 32'(bus.cpu_reset_n), 32'd0);
    check_output("rst_we", 32'(bus.imem_we), 32'd0);
    check_output("rst_done", 32'(bus.load_done), 32'd0);
    check_output("rst_err", 32'(bus.load_error), 32'd0);
    check_output("rst_addr", 32'(bus.imem_addr), 32'd0);
    check_output("rst_wdata", 32'(bus.imem_wdata), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_rst_ready", 32'(bus.rx_ready), 32'd1);

    // Directed frames.
    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);

    // Reset in the middle of a load: two words land, nothing after.
    got.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h48, 0);
    send_byte(8'h10, 0);
    send_byte(8'h12, 0);
    send_byte(8'h00, 0);
    idle(1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_output("mid_rst_ready", 32'(bus.rx_ready), 32'd0);
    check_output("mid_rst_rstn", 32'(bus.cpu_reset_n), 32'd0);
    check_output("mid_rst_err", 32'(bus.load_error), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("mid_post_ready", 32'(bus.rx_ready), 32'd1);
    send_byte(8'h70, 0);
    send_byte(8'h20, 0);
    send_byte(8'h80, 0);
    send_byte(8'h05, 0);
    send_byte(8'h9F, 0);
    idle(3);
    exp_wr.delete();
    exp_wr.push_back(24'h00_4810);
    exp_wr.push_back(24'h01_1200);
    check_writes("mid_rst");
    check_output("mid_rst_done", 32'(bus.load_done), 32'd0);
    apply_stimulus(vecs[0]);

    // Random framed streams with garbage and idle gaps.
    exp_status = 1;
    for (int r = 0; r < 40; r++) begin
      s.delete();
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        s.push_back(b);
      end
      s.push_back(8'hA5);
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      s.push_back(8'(len));
      if (len != 0) begin
        x = 8'h00;
        for (int k = 0; k < 2 * len; k++) begin
          b = 8'($urandom_range(0, 255));
          x = x ^ b;
          s.push_back(b);
        end
        if ($urandom_range(0, 2) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
        s.push_back(x);
      end
      ref_parse(s);
      got.delete();
      for (int k = 0; k < s.size(); k++) send_byte(s[k], $urandom_range(0, 2));
      idle(3);
      check_writes("rand");
      check_output("rand_done", 32'(bus.load_done), 32'(exp_status == 1));
      check_output("rand_rstn", 32'(bus.cpu_reset_n), 32'(exp_status == 1));
      check_output("rand_err", 32'(bus.load_error), 32'(exp_status == 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the RISC processor's instruction memory. It receives a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them into the instruction ROM at consecutive addresses. It holds the processor in reset until a complete frame with a correct checksum has been written.

## Interface

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- ADDR_W, 8, instruction memory address width; must match the processor PC width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  write address (word index).
- imem_wdata  output  16  write data, {hi_byte, lo_byte}.
- cpu_reset_n  output  1  drives the processor's active-low reset.
- load_done  output  1  a valid program is loaded and the CPU is released.
- load_error  output  1  the last frame was rejected.

## Operation

- **Byte acceptance.** A byte is accepted on a rising edge when rx_valid and rx_ready are both 1. Unaccepted bytes must be held by the sender.
- **Frame format:** SYNC_BYTE, LEN (1..255 words), then LEN × {hi, lo}, then CSUM.
  - CSUM is the XOR of all hi/lo payload bytes.
  - SYNC_BYTE and LEN are excluded from CSUM.
- **FSM states and transitions:**
  - SYNC: accepted byte == SYNC_BYTE → LEN, clear csum and idx. Any other byte is discarded; stay in SYNC.
  - LEN: byte == 0 → ERR. Otherwise latch len → HI.
  - HI: latch hi, csum ^= byte → LO.
  - LO: latch lo, csum ^= byte → WR.
  - WR: imem_we=1, imem_addr=idx, imem_wdata={hi,lo}. If idx == len-1 → CSUM; otherwise idx+1 → HI.
  - CSUM: byte == csum → DONE; otherwise → ERR.
  - DONE: cpu_reset_n=1, load_done=1. An accepted SYNC_BYTE → LEN. Other bytes are accepted and discarded.
  - ERR: load_error=1. An accepted SYNC_BYTE → LEN. Other bytes are accepted and discarded.
- **rx_ready:** 1 in every state except WR; 0 while reset is low.
- **Moore outputs** (decoded from the state register):
  - cpu_reset_n = (state == DONE)
  - load_done = (state == DONE)
  - load_error = (state == ERR)
  - imem_we = (state == WR)
- **Width rules:**
  - idx is ADDR_W bits and never wraps, because len ≤ 255.
  - csum is 8 bits.
  - imem_addr/imem_wdata are don't-care when imem_we = 0, but are held stable.
- **Re-load:** a SYNC_BYTE accepted in DONE pulls cpu_reset_n low on the next cycle; the processor stays in reset for the whole new load.
- **Reset mid-load:** state → SYNC and all outputs go to their reset values. Words already written remain in memory; no further writes occur.

## Timing

- Reset values: rx_ready=0 (during reset), imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset_n=0, load_done=0, load_error=0. rx_ready=1 on the first cycle after reset is released.
- Write timing: imem_we is high for exactly one cycle, the cycle after the lo byte is accepted. Memory samples on the following edge.
- Minimum word period is 3 cycles (HI, LO, WR), so sustained throughput is 2 bytes per 3 cycles.
- cpu_reset_n and load_done rise the cycle after a correct CSUM byte is accepted.
- load_error rises the cycle after a bad CSUM byte, or after LEN = 0, is accepted.
- If rx_valid is held high through WR, the byte is not consumed during WR and is accepted on the next cycle.

## Test plan

1. **Reset.** Hold reset low for 2 cycles. During reset: rx_ready=0, cpu_reset_n=0, imem_we=0, load_done=0, load_error=0. Next cycle: rx_ready=1.
2. **Normal load.** Send A5,04,48,10,12,00,70,20,80,05,9F back-to-back with rx_valid held high.
   - Four writes: addr 00=4810, 01=1200, 02=7020, 03=8005.
   - rx_ready=0 in each WR cycle.
   - cpu_reset_n=1 and load_done=1 exactly one cycle after 9F is accepted.
3. **Bad checksum.** Send the same frame with CSUM=9E. Four writes still occur, then load_error=1, cpu_reset_n stays 0, load_done=0.
4. **Zero length / garbage.**
   - Send A5,00: ERR with no writes.
   - Then send 00,FF,5A,A5,01,12,34,26: the 00,FF,5A bytes are discarded, one write addr 00=1234 occurs, then DONE, and load_error clears.
5. **Re-load from DONE.** After test 2, send A5. cpu_reset_n=0 and load_done=0 on the next cycle. The following frame A5-less payload 01,AB,CD,66 writes addr 00=ABCD and reaches DONE.
6. **Reset mid-load.** Send A5,04 and two words, then pulse reset low. Only addr 00–01 are written, state returns to SYNC, and cpu_reset_n=0. A subsequent full frame loads correctly.
